// File: rtl/sqm_pkg.sv
// Shared types and defaults for the square-wave period/high-time meter.
package sqm_pkg;

   typedef enum logic [1:0] {
      S_WAIT_LOW,
      S_WAIT_RISE,
      S_HIGH,
      S_LOW
   } sqm_state_e;

   localparam int CNT_W_DEF       = 28;
   localparam int TIMEOUT_CYC_DEF = 100_000_000;
   localparam int FILT_LEN_DEF    = 4;

endpackage

// File: rtl/sqm_input_cond.sv
// Input conditioning: 2-flop synchronizer, optional glitch filter
// (SQM_GLITCH_FILTER_EN) and registered rise/fall edge pulses.
module sqm_input_cond
   import sqm_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic sys_clk_i,
   input  logic ext_rst_n,
   input  logic sig_i,
   output logic sig_c,
   output logic rise_p,
   output logic fall_p
);

   logic [1:0] sync;
   logic       sig_d;
   logic       sig_dd;

   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], sig_i};
      end
   end

`ifdef SQM_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);

   logic [FC_W-1:0] fcnt;
   logic            filt;

   // Output follows only after FILT_LEN consecutive differing samples.
   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         fcnt <= '0;
         filt <= 1'b0;
      end else if (sync[1] != filt) begin
         if (fcnt == FC_W'(FILT_LEN - 1)) begin
            filt <= sync[1];
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end else begin
         fcnt <= '0;
      end
   end

   assign sig_c = filt;
`else
   assign sig_c = sync[1];
`endif

   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         sig_d  <= 1'b0;
         sig_dd <= 1'b0;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else begin
         sig_d  <= sig_c;
         sig_dd <= sig_d;
         rise_p <= sig_d & ~sig_dd;
         fall_p <= ~sig_d & sig_dd;
      end
   end

endmodule

// File: rtl/sq_wave_meter.sv
// Square-wave meter: period and high time in sys_clk_i cycles, with timeout.
// Optional glitch filter enabled by defining SQM_GLITCH_FILTER_EN.
module sq_wave_meter
   import sqm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF
) (
   input  logic             sys_clk_i,
   input  logic             ext_rst_n,
   input  logic             sig_i,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             meas_valid,
   output logic             timeout_o,
   output logic             locked_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   sqm_state_e       state;
   sqm_state_e       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] idle;
   logic [CNT_W-1:0] hi_lat;
   logic             sig_c;
   logic             rise_p;
   logic             fall_p;
   logic             cnt_to;
   logic             idle_to;
   logic             publish;
   logic             to_hit;
   logic             counting;

`ifdef SQM_GLITCH_FILTER_EN
   sqm_input_cond #(
      .FILT_LEN(FILT_LEN)
   ) u_cond (
`else
   sqm_input_cond u_cond (
`endif
      .sys_clk_i(sys_clk_i),
      .ext_rst_n(ext_rst_n),
      .sig_i    (sig_i),
      .sig_c    (sig_c),
      .rise_p   (rise_p),
      .fall_p   (fall_p)
   );

   assign cnt_to  = (cnt == CNT_MAX);
   assign idle_to = (idle == CNT_MAX);

   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         state <= S_WAIT_LOW;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_WAIT_LOW: begin
            if (!sig_c) state_nx = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (rise_p) state_nx = S_HIGH;
         end
         S_HIGH: begin
            if (fall_p)      state_nx = S_LOW;
            else if (cnt_to) state_nx = S_WAIT_LOW;
         end
         S_LOW: begin
            if (rise_p)      state_nx = S_HIGH;
            else if (cnt_to) state_nx = S_WAIT_RISE;
         end
         default: state_nx = S_WAIT_LOW;
      endcase
   end

   // An edge in the timeout cycle wins over the timeout.
   always_comb begin
      counting = (state == S_HIGH) || (state == S_LOW);
      locked_o = counting;
      publish  = (state == S_LOW) && rise_p;
      to_hit   = ((state == S_HIGH) && !fall_p && cnt_to) ||
                 ((state == S_LOW) && !rise_p && cnt_to) ||
                 ((state == S_WAIT_RISE) && !rise_p && idle_to);
   end

   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         cnt         <= '0;
         idle        <= '0;
         hi_lat      <= '0;
         meas_period <= '0;
         meas_high   <= '0;
         meas_valid  <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         meas_valid <= publish;
         if (publish) begin
            meas_period <= cnt;
            meas_high   <= hi_lat;
            timeout_o   <= 1'b0;
         end else if (to_hit) begin
            timeout_o <= 1'b1;
         end
         if (rise_p && ((state == S_WAIT_RISE) || (state == S_LOW))) begin
            cnt <= CNT_W'(1);
         end else if (counting && !cnt_to) begin
            cnt <= cnt + 1'b1;
         end
         if ((state == S_HIGH) && fall_p) begin
            hi_lat <= cnt;
         end
         if (state != S_WAIT_RISE) begin
            idle <= '0;
         end else if (!idle_to) begin
            idle <= idle + 1'b1;
         end
      end
   end

endmodule

// File: doc/sq_wave_meter.md
SQ_WAVE_METER -- requirements
Module: sq_wave_meter

Interface
REQ-001 Parameter CNT_W, default 28; width of all cycle counts.
REQ-002 Parameter TIMEOUT_CYC, default 100_000_000; cycles without an edge before timeout (2 s at 50 MHz).
REQ-003 Parameter FILT_LEN, default 4; glitch-filter length in cycles. Used only when SQM_GLITCH_FILTER_EN is defined.
REQ-004 sys_clk_i  input  1  50 MHz system clock.
REQ-005 ext_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sig_i  input  1  asynchronous square wave to measure (buzzer feedback or sensor).
REQ-007 meas_period  output  CNT_W  cycles between the last two rising edges.
REQ-008 meas_high  output  CNT_W  cycles from the rising edge to the falling edge in the same period.
REQ-009 meas_valid  output  1  one-cycle strobe; meas_period and meas_high were updated this cycle.
REQ-010 timeout_o  output  1  sticky flag; no edge seen for TIMEOUT_CYC cycles.
REQ-011 locked_o  output  1  high while in S_HIGH or S_LOW.

Function
REQ-012 sig_i passes through a 2-flop synchronizer, then edge detection; rise_p and fall_p are one-cycle pulses.
REQ-013 Without the filter, rise_p asserts exactly 3 cycles after the first sys_clk_i edge that samples sig_i high.
REQ-014 State machine states: S_WAIT_LOW, S_WAIT_RISE, S_HIGH, S_LOW.
REQ-015 S_WAIT_LOW: go to S_WAIT_RISE when the conditioned signal is low. No measurement occurs in this state.
REQ-016 S_WAIT_RISE: on rise_p, set cnt to 1 and go to S_HIGH. The first rising edge produces no meas_valid.
REQ-017 S_HIGH: cnt increments every cycle. On fall_p, hi_lat gets cnt and the state goes to S_LOW.
REQ-018 S_LOW: cnt increments. On rise_p, in the same cycle:
  - meas_period gets cnt and meas_high gets hi_lat;
  - meas_valid pulses for one cycle;
  - timeout_o clears and cnt is set to 1;
  - state goes to S_HIGH.
REQ-019 A period of P cycles with high time H reports meas_period = P and meas_high = H exactly.
REQ-020 cnt saturates at TIMEOUT_CYC and never wraps.
REQ-021 Timeout: when cnt reaches TIMEOUT_CYC, timeout_o sets.
  - From S_HIGH, the state goes to S_WAIT_LOW.
  - From S_LOW, the state goes to S_WAIT_RISE.
  - meas_period and meas_high hold their last values.
REQ-022 In S_WAIT_RISE, a separate idle counter applies the same timeout rule and sets timeout_o. The state stays S_WAIT_RISE.
REQ-023 If rise_p and the timeout condition occur in the same cycle, rise_p wins: the measurement is published and timeout_o is not set.
REQ-024 meas_period and meas_high change only in a cycle where meas_valid = 1.

Reset
REQ-025 While ext_rst_n is low:
  - state = S_WAIT_LOW;
  - cnt, the idle counter, hi_lat, meas_period and meas_high = 0;
  - meas_valid, timeout_o and locked_o = 0;
  - synchronizer, filter and edge-detect flops = 0.
REQ-026 Asserting reset mid-measurement discards the partial period. After release, the first meas_valid needs a low, a rise, a fall and a second rise.

Configuration
REQ-027 Macro SQM_GLITCH_FILTER_EN.
  - Defined: the conditioned signal changes only after FILT_LEN consecutive equal synchronized samples that differ from its current value. Pulses shorter than FILT_LEN cycles are ignored. Edge latency grows by exactly FILT_LEN cycles. Measured values are unchanged for clean input.
  - Undefined: the synchronizer output feeds edge detection directly. No filter flops exist.

Structure
REQ-028 Package sqm_pkg holds:
  - the state enum (S_WAIT_LOW, S_WAIT_RISE, S_HIGH, S_LOW);
  - CNT_W_DEF = 28;
  - TIMEOUT_CYC_DEF = 100_000_000;
  - FILT_LEN_DEF = 4.
REQ-029 Sub-module sqm_input_cond holds the synchronizer, the optional filter and edge detection. It outputs sig_c, rise_p and fall_p. The top level holds the state machine and counters.

Verification (simulate with TIMEOUT_CYC = 1000)
REQ-030 Square wave, period 100 cycles, high 50, five periods:
  - meas_valid pulses 4 times;
  - each pulse reports meas_period = 100 and meas_high = 50;
  - locked_o = 1 after the first rise.
REQ-031 Period 60, high 15: meas_period = 60 and meas_high = 15. Then switch to period 200, high 150: the first full new period reports 200 and 150.
REQ-032 Hold sig_i high for 1200 cycles mid-measurement:
  - timeout_o = 1 at cnt = 1000;
  - state is S_WAIT_LOW;
  - no meas_valid pulses.
  Then resume period 100: timeout_o clears on the second rise after resume, with meas_period = 100.
REQ-033 Pulse ext_rst_n low for 3 cycles during S_LOW: all outputs are 0 immediately, and the first meas_valid follows the second clean rise.
REQ-034 With SQM_GLITCH_FILTER_EN defined, inject 2-cycle glitches into a period-100 / high-50 wave: every report is still 100/50. Without the macro, the same stimulus produces wrong short periods.
REQ-035 Align sig_i's rise with cnt = 999 in S_LOW (period 999): meas_valid pulses with meas_period = 999 and timeout_o stays 0.
